// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master / register-file subsystem.
package apb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    typedef struct packed {
        logic ready;
        logic err;
    } resp_t;

    localparam resp_t DECODE_ERR_RESP = '{ready: 1'b1, err: 1'b1};

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: byte-strobed APB register file with a fixed number of wait states per access.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SLAVE_DEPTH = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [clog2(SLAVE_DEPTH)-1:0] paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W/8-1:0]        pstrb,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready
);
    logic [3:0]        cnt;
    logic [DATA_W-1:0] mem [SLAVE_DEPTH];

    assign pready = cnt == 4'(WAIT_CYCLES);
    assign prdata = pready ? mem[paddr] : '0;

    // SETUP clears the counter so every ACCESS phase starts from zero
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (psel && !penable)
            cnt <= '0;
        else if (psel && penable && !pready)
            cnt <= cnt + 4'd1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < SLAVE_DEPTH; i++)
                mem[i] <= '0;
        end else if (psel && penable && pwrite && pready) begin
            for (int b = 0; b < DATA_W / 8; b++)
                if (pstrb[b])
                    mem[paddr][b*8 +: 8] <= pwdata[b*8 +: 8];
        end
endmodule

// File: rtl/apb_subsystem.sv
// apb_subsystem: APB master FSM with address decode driving NUM_SLAVES register-file slaves.
module apb_subsystem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int NUM_SLAVES  = 2,
    parameter int SLAVE_DEPTH = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transfer,
    input  logic                read_write,
    input  logic [ADDR_W-1:0]   apb_read_add,
    input  logic [ADDR_W-1:0]   apb_write_add,
    input  logic [DATA_W-1:0]   apb_write_data,
    input  logic [DATA_W/8-1:0] apb_write_strb,
    output logic [DATA_W-1:0]   pr_data,
    output logic                ready,
    output logic                slv_err,
    output logic                busy
);
    localparam int SEL_W = clog2(NUM_SLAVES) < 1 ? 1 : clog2(NUM_SLAVES);
    localparam int IDX_W = clog2(SLAVE_DEPTH);
    // bits between the slave index and the word offset must be zero for a mapped address
    localparam logic [ADDR_W-1:0] GAP_MASK =
        ADDR_W'(((64'd1 << (ADDR_W - SEL_W)) - 64'd1) & ~((64'd1 << IDX_W) - 64'd1));
    localparam logic [SEL_W:0] SLV_CNT = NUM_SLAVES[SEL_W:0];

    state_t                  state;
    logic [ADDR_W-1:0]       paddr;
    logic [DATA_W-1:0]       pwdata;
    logic [DATA_W/8-1:0]     pstrb;
    logic                    pwrite;
    logic                    penable;
    logic [SEL_W-1:0]        sel_idx;
    logic                    dec_err;
    logic                    capture;
    logic                    done;
    logic [NUM_SLAVES-1:0]   psel_v;
    logic [NUM_SLAVES-1:0]   s_ready;
    logic [DATA_W-1:0]       s_rdata [NUM_SLAVES];
    logic [DATA_W-1:0]       prdata_m;
    logic                    pready_m;
    logic                    pslverr_m;

    assign busy    = state != IDLE;
    assign penable = state == ACCESS;
    assign sel_idx = paddr[ADDR_W-1 -: SEL_W];
    assign dec_err = ({1'b0, sel_idx} >= SLV_CNT) || |(paddr & GAP_MASK);
    assign done    = penable && pready_m;
    assign capture = transfer && (state == IDLE || done);

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
        assign psel_v[i] = busy && !dec_err && sel_idx == SEL_W'(i);
        apb_reg_slave #(
            .DATA_W      (DATA_W),
            .SLAVE_DEPTH (SLAVE_DEPTH),
            .WAIT_CYCLES (WAIT_CYCLES)
        ) u_slv (
            .clk     (clk),
            .rst     (rst),
            .psel    (psel_v[i]),
            .penable (penable),
            .pwrite  (pwrite),
            .paddr   (paddr[IDX_W-1:0]),
            .pwdata  (pwdata),
            .pstrb   (pstrb),
            .prdata  (s_rdata[i]),
            .pready  (s_ready[i])
        );
    end

    always_comb begin
        prdata_m  = '0;
        pready_m  = dec_err ? DECODE_ERR_RESP.ready : 1'b0;
        pslverr_m = dec_err ? DECODE_ERR_RESP.err : 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (psel_v[i]) begin
                prdata_m = s_rdata[i];
                pready_m = s_ready[i];
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
            pwrite <= 1'b0;
        end else if (capture) begin
            paddr  <= read_write ? apb_write_add : apb_read_add;
            pwdata <= apb_write_data;
            pstrb  <= apb_write_strb;
            pwrite <= read_write;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            ready   <= 1'b0;
            slv_err <= 1'b0;
            pr_data <= '0;
        end else begin
            state   <= capture ? SETUP : state == SETUP ? ACCESS : (penable && !pready_m) ? ACCESS : IDLE;
            ready   <= done;
            slv_err <= done && pslverr_m;
            if (done && !pwrite)
                pr_data <= pslverr_m ? '0 : prdata_m;
        end
endmodule

// File: tb/tb_apb_subsystem.sv
// tb_apb_subsystem: directed checks of three apb_subsystem configurations.
module tb_apb_subsystem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  tr = '0;
    logic        rw = 1'b0;
    logic [7:0]  raddr = '0;
    logic [7:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;
    logic [7:0]  prd_a, prd_c;
    logic [31:0] prd_b;
    logic [2:0]  rdy, err, bsy;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apb_subsystem dut_a (
        .clk(clk), .rst(rst), .transfer(tr[0]), .read_write(rw),
        .apb_read_add(raddr), .apb_write_add(waddr),
        .apb_write_data(wdata[7:0]), .apb_write_strb(strb[0:0]),
        .pr_data(prd_a), .ready(rdy[0]), .slv_err(err[0]), .busy(bsy[0])
    );

    apb_subsystem #(.DATA_W(32), .NUM_SLAVES(3), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .transfer(tr[1]), .read_write(rw),
        .apb_read_add(raddr), .apb_write_add(waddr),
        .apb_write_data(wdata), .apb_write_strb(strb),
        .pr_data(prd_b), .ready(rdy[1]), .slv_err(err[1]), .busy(bsy[1])
    );

    apb_subsystem #(.WAIT_CYCLES(2)) dut_c (
        .clk(clk), .rst(rst), .transfer(tr[2]), .read_write(rw),
        .apb_read_add(raddr), .apb_write_add(waddr),
        .apb_write_data(wdata[7:0]), .apb_write_strb(strb[0:0]),
        .pr_data(prd_c), .ready(rdy[2]), .slv_err(err[2]), .busy(bsy[2])
    );

    // the unused address port gets the complement so a wrong address mux is visible
    task automatic drive_req(input bit w, input logic [7:0] a, input logic [31:0] dt, input logic [3:0] s);
        rw    = w;
        waddr = w ? a : ~a;
        raddr = w ? ~a : a;
        wdata = dt;
        strb  = s;
    endtask

    task automatic xfer(input int d, input bit w, input logic [7:0] a, input logic [31:0] dt,
                        input logic [3:0] s, output int lat, output bit e, output logic [31:0] rd);
        @(negedge clk);
        drive_req(w, a, dt, s);
        tr[d] = 1'b1;
        @(negedge clk);
        tr[d] = 1'b0;
        drive_req(!w, ~a, ~dt, ~s);
        lat = 1;
        while (!rdy[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e  = err[d];
        rd = d == 0 ? {24'h0, prd_a} : d == 1 ? prd_b : {24'h0, prd_c};
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy, err, bsy} !== 9'h0 || prd_a !== 8'h0 || prd_b !== 32'h0 || prd_c !== 8'h0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b err=%b bsy=%b prd=%h/%h/%h want all zero", rdy, err, bsy, prd_a, prd_b, prd_c);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat; bit e; logic [31:0] rd;
        xfer(0, 1'b1, 8'h03, 32'hA5, 4'h1, lat, e, rd);
        checks++;
        if (lat !== 3 || e !== 1'b0) begin failures++; $display("FAIL basic_wr lat=%0d err=%b want 3/0", lat, e); end
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b0) begin failures++; $display("FAIL basic_pulse ready=%b want 0", rdy[0]); end
        xfer(0, 1'b0, 8'h03, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd[7:0] !== 8'hA5) begin
            failures++; $display("FAIL basic_rd lat=%0d err=%b data=%h want 3/0/a5", lat, e, rd[7:0]);
        end
        xfer(0, 1'b0, 8'h83, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (e !== 1'b0 || rd[7:0] !== 8'h00) begin failures++; $display("FAIL basic_rd_s1 err=%b data=%h want 0/00", e, rd[7:0]); end
        xfer(0, 1'b0, 8'h03, 32'h0, 4'h0, lat, e, rd);
        xfer(0, 1'b1, 8'h83, 32'h5C, 4'h1, lat, e, rd);
        checks++;
        if (rd[7:0] !== 8'hA5) begin failures++; $display("FAIL basic_hold_on_write data=%h want a5", rd[7:0]); end
        xfer(0, 1'b0, 8'h83, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (rd[7:0] !== 8'h5C) begin failures++; $display("FAIL basic_s1_data data=%h want 5c", rd[7:0]); end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit e; logic [31:0] rd;
        @(negedge clk);
        drive_req(1'b0, 8'h03, 32'h0, 4'h0);
        tr[0] = 1'b1;
        @(negedge clk);
        tr[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (prd_a !== 8'h0 || rdy !== 3'b0 || err !== 3'b0 || bsy !== 3'b0) begin
            failures++; $display("FAIL reset_mid_run prd=%h rdy=%b err=%b bsy=%b want zeros", prd_a, rdy, err, bsy);
        end
        @(negedge clk);
        rst = 1'b1;
        xfer(0, 1'b0, 8'h03, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (rd[7:0] !== 8'h00 || lat !== 3) begin failures++; $display("FAIL reset_mem_clear data=%h lat=%0d want 00/3", rd[7:0], lat); end
    endtask

    task automatic test_strobes();
        int lat; bit e; logic [31:0] rd;
        xfer(1, 1'b1, 8'h45, 32'h11223344, 4'b1111, lat, e, rd);
        checks++;
        if (lat !== 6 || e !== 1'b0) begin failures++; $display("FAIL strb_wr1 lat=%0d err=%b want 6/0", lat, e); end
        xfer(1, 1'b1, 8'h45, 32'hAABBCCDD, 4'b0101, lat, e, rd);
        xfer(1, 1'b0, 8'h45, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (rd !== 32'h11BB33DD || e !== 1'b0 || lat !== 6) begin
            failures++; $display("FAIL strb_rd data=%h err=%b lat=%0d want 11bb33dd/0/6", rd, e, lat);
        end
    endtask

    task automatic test_wait_states();
        int lat = 0; int acc = 0; bit e; logic [31:0] rd;
        @(negedge clk);
        drive_req(1'b1, 8'h8A, 32'hCAFEF00D, 4'hF);
        tr[1] = 1'b1;
        @(negedge clk);
        tr[1] = 1'b0;
        drive_req(1'b0, 8'h75, 32'h0, 4'h0);
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            if (dut_b.penable) begin
                acc++;
                checks++;
                if (dut_b.paddr !== 8'h8A || dut_b.pwdata !== 32'hCAFEF00D) begin
                    failures++; $display("FAIL ws_bus_stable cycle=%0d paddr=%h pwdata=%h want 8a/cafef00d", c, dut_b.paddr, dut_b.pwdata);
                end
            end
            if (rdy[1]) lat = c;
            else @(negedge clk);
        end
        checks++;
        if (acc !== 4 || lat !== 6) begin failures++; $display("FAIL ws_write access_cycles=%0d lat=%0d want 4/6", acc, lat); end
        xfer(1, 1'b0, 8'h8A, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (lat !== 6 || rd !== 32'hCAFEF00D) begin failures++; $display("FAIL ws_read lat=%0d data=%h want 6/cafef00d", lat, rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ad [4];
        int          rc [8];
        logic [31:0] rdv [8];
        bit          ev [8];
        int          cyc, nr, drops;
        ad = '{8'h01, 8'h42, 8'h83, 8'h0F};
        @(negedge clk);
        drive_req(1'b1, ad[0], 32'hB2B00000, 4'hF);
        tr[1] = 1'b1;
        @(negedge clk);
        cyc = 1;
        drive_req(1'b1, ad[1], 32'hB2B11111, 4'hF);
        nr = 0;
        drops = 0;
        while (nr < 8 && cyc < 100) begin
            if (!(rdy[1] && nr == 7) && !bsy[1]) drops++;
            if (rdy[1]) begin
                rc[nr]  = cyc;
                rdv[nr] = prd_b;
                ev[nr]  = err[1];
                nr++;
                if (nr + 1 < 8) drive_req(nr + 1 < 4, ad[(nr + 1) % 4], 32'hB2B00000 + 32'((nr + 1) % 4) * 32'h00011111, 4'hF);
                else tr[1] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tr[1] = 1'b0;
        checks++;
        if (nr !== 8 || drops !== 0) begin failures++; $display("FAIL b2b_busy completed=%0d busy_drops=%0d want 8/0", nr, drops); end
        for (int k = 0; k < nr; k++) begin
            checks++;
            if (rc[k] !== 6 + 5 * k || ev[k] !== 1'b0) begin
                failures++; $display("FAIL b2b_ready_cycle xfer=%0d cycle=%0d err=%b want %0d/0", k, rc[k], ev[k], 6 + 5 * k);
            end
            if (k >= 4) begin
                checks++;
                if (rdv[k] !== 32'hB2B00000 + 32'(k - 4) * 32'h00011111) begin
                    failures++; $display("FAIL b2b_read_data xfer=%0d data=%h want %h", k, rdv[k], 32'hB2B00000 + 32'(k - 4) * 32'h00011111);
                end
            end
        end
    endtask

    task automatic test_errors();
        int lat; bit e; logic [31:0] rd;
        xfer(1, 1'b1, 8'h00, 32'h12345678, 4'hF, lat, e, rd);
        xfer(1, 1'b1, 8'h80, 32'h9ABCDEF0, 4'hF, lat, e, rd);
        xfer(1, 1'b1, 8'hC0, 32'hFFFFFFFF, 4'hF, lat, e, rd);
        checks++;
        if (e !== 1'b1 || lat !== 3) begin failures++; $display("FAIL err_wr_idx3 err=%b lat=%0d want 1/3", e, lat); end
        xfer(1, 1'b1, 8'h10, 32'hEEEEEEEE, 4'hF, lat, e, rd);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL err_wr_gap err=%b want 1", e); end
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (e !== 1'b0 || rd !== 32'h12345678) begin failures++; $display("FAIL err_mem_s0 err=%b data=%h want 0/12345678", e, rd); end
        xfer(1, 1'b0, 8'h80, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (e !== 1'b0 || rd !== 32'h9ABCDEF0) begin failures++; $display("FAIL err_mem_s2 err=%b data=%h want 0/9abcdef0", e, rd); end
        xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            failures++; $display("FAIL err_rd_gap err=%b data=%h lat=%0d want 1/00000000/3", e, rd, lat);
        end
        @(negedge clk);
        checks++;
        if (err[1] !== 1'b0 || rdy[1] !== 1'b0) begin failures++; $display("FAIL err_clears err=%b ready=%b want 0/0", err[1], rdy[1]); end
    endtask

    task automatic test_reset_mid_access();
        int lat; bit e; logic [31:0] rd;
        @(negedge clk);
        drive_req(1'b1, 8'h05, 32'h77, 4'h1);
        tr[2] = 1'b1;
        @(negedge clk);
        tr[2] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bsy[2] !== 1'b1 || dut_c.penable !== 1'b1) begin failures++; $display("FAIL rma_in_access busy=%b penable=%b want 1/1", bsy[2], dut_c.penable); end
        rst = 1'b0;
        #1;
        checks++;
        if (bsy[2] !== 1'b0 || rdy[2] !== 1'b0) begin failures++; $display("FAIL rma_idle busy=%b ready=%b want 0/0", bsy[2], rdy[2]); end
        @(negedge clk);
        rst = 1'b1;
        xfer(2, 1'b0, 8'h05, 32'h0, 4'h0, lat, e, rd);
        checks++;
        if (rd[7:0] !== 8'h00 || lat !== 5 || e !== 1'b0) begin
            failures++; $display("FAIL rma_read data=%h lat=%0d err=%b want 00/5/0", rd[7:0], lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_strobes();
        test_wait_states();
        test_back_to_back();
        test_errors();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
